// File: rtl/alu_mdu_control.sv
// EX-stage ALU/MDU control: combinational ALU/result-select decode plus a
// start/run/done sequencer for iterative MULTU/DIVU with stall, commit and abort.
module alu_mdu_control #(
    parameter int WIDTH       = 32,
    parameter bit SUPPORT_DIV = 1'b1,
    localparam int CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic             Valid,
    input  logic             Kill,
    output logic [2:0]       ALUOperation,
    output logic [1:0]       Sel,
    output logic [5:0]       MDUOperation,
    output logic             MDUStart,
    output logic             HiLoWrite,
    output logic             Stall,
    output logic             Busy,
    output logic [CNT_W-1:0] Count
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SRL = 3'b011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] OP_HILO  = 6'b111111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [5:0]       mdu_op_r, mdu_op_nxt_s;
    logic [2:0]       alu_op_s;
    logic [1:0]       sel_s;
    logic             is_mdu_s, start_s;
    logic             mdu_start_s, stall_fsm_s, hlw_fsm_s;

    assign is_mdu_s = (Funct == FN_MULTU) || ((SUPPORT_DIV != 1'b0) && (Funct == FN_DIVU));
    assign start_s  = Valid && (ALUOp == 2'b10) && is_mdu_s && !Kill;

    // ALU operation and result-select decode
    always_comb begin
        alu_op_s = 3'bxxx;
        sel_s    = 2'b00;
        case (ALUOp)
            2'b00: alu_op_s = ALU_ADD;
            2'b01: alu_op_s = ALU_SUB;
            2'b10: begin
                case (Funct)
                    FN_ADD:   alu_op_s = ALU_ADD;
                    FN_SUB:   alu_op_s = ALU_SUB;
                    FN_AND:   alu_op_s = ALU_AND;
                    FN_OR:    alu_op_s = ALU_OR;
                    FN_SLT:   alu_op_s = ALU_SLT;
                    FN_SRL:   alu_op_s = ALU_SRL;
                    FN_MULTU: alu_op_s = ALU_ADD;
                    FN_MFHI: begin
                        alu_op_s = ALU_ADD;
                        sel_s    = 2'b01;
                    end
                    FN_MFLO: begin
                        alu_op_s = ALU_ADD;
                        sel_s    = 2'b10;
                    end
                    FN_DIVU: begin
                        if (SUPPORT_DIV != 1'b0) begin
                            alu_op_s = ALU_ADD;
                        end else begin
                            alu_op_s = 3'bxxx;
                        end
                    end
                    default: alu_op_s = 3'bxxx;
                endcase
            end
            default: alu_op_s = 3'bxxx;
        endcase
    end

    // Sequencer next-state, counter and latched-operation logic
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        mdu_op_nxt_s = mdu_op_r;
        mdu_start_s  = 1'b0;
        stall_fsm_s  = 1'b0;
        hlw_fsm_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                count_nxt_s = '0;
                if (start_s) begin
                    mdu_start_s  = 1'b1;
                    stall_fsm_s  = 1'b1;
                    state_nxt_s  = ST_RUN;
                    mdu_op_nxt_s = Funct;
                end else begin
                    mdu_op_nxt_s = 6'b000000;
                end
            end
            ST_RUN: begin
                stall_fsm_s = 1'b1;
                if (Kill) begin
                    state_nxt_s  = ST_IDLE;
                    count_nxt_s  = '0;
                    mdu_op_nxt_s = 6'b000000;
                end else begin
                    count_nxt_s = count_r + CNT_W'(1);
                    if (count_r == CNT_LAST) begin
                        state_nxt_s  = ST_DONE;
                        mdu_op_nxt_s = OP_HILO;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                // The MULTU/DIVU leaving EX here must not retrigger, so no start check.
                hlw_fsm_s    = 1'b1;
                state_nxt_s  = ST_IDLE;
                count_nxt_s  = '0;
                mdu_op_nxt_s = 6'b000000;
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                count_nxt_s  = '0;
                mdu_op_nxt_s = 6'b000000;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            count_r  <= '0;
            mdu_op_r <= 6'b000000;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            mdu_op_r <= mdu_op_nxt_s;
        end
    end

    // Kill and Reset both mask the pulses immediately, not one edge later.
    assign ALUOperation = alu_op_s;
    assign Sel          = sel_s;
    assign MDUOperation = mdu_op_r;
    assign MDUStart     = mdu_start_s && !Reset;
    assign Stall        = stall_fsm_s && !Kill && !Reset;
    assign HiLoWrite    = hlw_fsm_s && !Kill && !Reset;
    assign Busy         = (state_r != ST_IDLE);
    assign Count        = count_r;

endmodule

// File: tb/tb_alu_mdu_control.sv
// Bench for alu_mdu_control: three instances (32-bit, 8-bit, 8-bit without DIVU),
// directed stimulus, HI/LO commits checked through per-instance scoreboards.
module tb_alu_mdu_control;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] HILO  = 6'b111111;

    typedef struct {
        int         cyc;
        logic [5:0] op;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t qn[$];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic Clk = 1'b0;
    logic r32, r8;

    logic [1:0] a32, a8, an;
    logic [5:0] f32, f8, fn;
    logic       v32, v8, vn, k32, k8, kn;

    logic [2:0] op32, op8, opn;
    logic [1:0] s32, s8, sn;
    logic [5:0] m32, m8, mn;
    logic       st32, st8, stn, h32, h8, hn, sl32, sl8, sln, b32, b8, bn;
    logic [5:0] c32;
    logic [3:0] c8, cn;

    alu_mdu_control #(.WIDTH(32), .SUPPORT_DIV(1'b1)) u32 (
        .Clk(Clk), .Reset(r32), .ALUOp(a32), .Funct(f32), .Valid(v32), .Kill(k32),
        .ALUOperation(op32), .Sel(s32), .MDUOperation(m32), .MDUStart(st32),
        .HiLoWrite(h32), .Stall(sl32), .Busy(b32), .Count(c32));

    alu_mdu_control #(.WIDTH(8), .SUPPORT_DIV(1'b1)) u8 (
        .Clk(Clk), .Reset(r8), .ALUOp(a8), .Funct(f8), .Valid(v8), .Kill(k8),
        .ALUOperation(op8), .Sel(s8), .MDUOperation(m8), .MDUStart(st8),
        .HiLoWrite(h8), .Stall(sl8), .Busy(b8), .Count(c8));

    alu_mdu_control #(.WIDTH(8), .SUPPORT_DIV(1'b0)) un (
        .Clk(Clk), .Reset(r8), .ALUOp(an), .Funct(fn), .Valid(vn), .Kill(kn),
        .ALUOperation(opn), .Sel(sn), .MDUOperation(mn), .MDUStart(stn),
        .HiLoWrite(hn), .Stall(sln), .Busy(bn), .Count(cn));

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitors: every HiLoWrite must match the next expected commit.
    always @(negedge Clk) begin
        if (h32) begin
            tests++;
            if (q32.size() == 0) begin
                failed++;
                $display("FAIL u32_commit @cyc %0d: unexpected HiLoWrite, none pending", cyc);
            end else begin
                exp_t e;
                e = q32.pop_front();
                if (e.cyc != cyc || m32 !== e.op) begin
                    failed++;
                    $display("FAIL u32_commit: got cyc %0d op %b, expected cyc %0d op %b", cyc, m32, e.cyc, e.op);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (h8) begin
            tests++;
            if (q8.size() == 0) begin
                failed++;
                $display("FAIL u8_commit @cyc %0d: unexpected HiLoWrite, none pending", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                if (e.cyc != cyc || m8 !== e.op) begin
                    failed++;
                    $display("FAIL u8_commit: got cyc %0d op %b, expected cyc %0d op %b", cyc, m8, e.cyc, e.op);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (hn) begin
            tests++;
            if (qn.size() == 0) begin
                failed++;
                $display("FAIL un_commit @cyc %0d: unexpected HiLoWrite, none pending", cyc);
            end else begin
                exp_t e;
                e = qn.pop_front();
                if (e.cyc != cyc || mn !== e.op) begin
                    failed++;
                    $display("FAIL un_commit: got cyc %0d op %b, expected cyc %0d op %b", cyc, mn, e.cyc, e.op);
                end
            end
        end
    end

    task automatic dec32(input logic [1:0] aluop, input logic [5:0] f, input int exp_op, input int exp_sel);
        a32 = aluop;
        f32 = f;
        #1;
        chk($sformatf("aluop_%b_%b", aluop, f), int'(op32), exp_op);
        chk($sformatf("sel_%b_%b", aluop, f), int'(s32), exp_sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        r32 = 1'b1; r8 = 1'b1;
        a32 = 2'b00; f32 = 6'b000000; v32 = 1'b0; k32 = 1'b0;
        a8  = 2'b00; f8  = 6'b000000; v8  = 1'b0; k8  = 1'b0;
        an  = 2'b00; fn  = 6'b000000; vn  = 1'b0; kn  = 1'b0;
        tick();
        tick();
        chk("rst_busy", int'(b32), 0);
        chk("rst_stall", int'(sl32), 0);
        chk("rst_count", int'(c32), 0);
        chk("rst_mduop", int'(m32), 0);
        chk("rst_hlw", int'(h32), 0);
        chk("rst_start", int'(st32), 0);
        r32 = 1'b0; r8 = 1'b0;

        // Decode sweep (Valid low so nothing starts)
        tick();
        dec32(2'b00, 6'b000000, 3'b010, 2'b00);
        dec32(2'b01, 6'b000000, 3'b110, 2'b00);
        dec32(2'b10, 6'b100000, 3'b010, 2'b00);
        dec32(2'b10, 6'b100010, 3'b110, 2'b00);
        dec32(2'b10, 6'b100100, 3'b000, 2'b00);
        dec32(2'b10, 6'b100101, 3'b001, 2'b00);
        dec32(2'b10, 6'b101010, 3'b111, 2'b00);
        dec32(2'b10, 6'b000010, 3'b011, 2'b00);
        a32 = 2'b10; f32 = 6'b010000; #1; chk("sel_mfhi", int'(s32), 1);
        f32 = 6'b010010; #1; chk("sel_mflo", int'(s32), 2);
        chk("idle_no_start", int'(st32), 0);

        // MULTU on the 32-bit instance, full latency
        tick();
        v32 = 1'b1; a32 = 2'b10; f32 = MULTU;
        #1;
        t = cyc;
        chk("m32_start", int'(st32), 1);
        chk("m32_stall_T", int'(sl32), 1);
        chk("m32_busy_T", int'(b32), 0);
        q32.push_back('{t + 33, HILO});
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("m32_stall_run", int'(sl32), 1);
            chk("m32_busy_run", int'(b32), 1);
            chk("m32_count", int'(c32), k - 1);
            if (k == 1) chk("m32_latched_op", int'(m32), int'(MULTU));
        end
        tick();
        chk("m32_done_stall", int'(sl32), 0);
        chk("m32_done_busy", int'(b32), 1);
        chk("m32_done_nostart", int'(st32), 0);
        chk("m32_done_hilo", int'(m32), int'(HILO));
        tick();
        v32 = 1'b0;
        #1;
        chk("m32_idle_busy", int'(b32), 0);
        chk("m32_idle_op", int'(m32), 0);

        // Kill at Count=5
        tick();
        v32 = 1'b1; f32 = MULTU;
        for (int k = 1; k <= 6; k++) tick();
        chk("kill_count5", int'(c32), 5);
        k32 = 1'b1;
        #1;
        chk("kill_stall", int'(sl32), 0);
        chk("kill_hlw", int'(h32), 0);
        tick();
        k32 = 1'b0; v32 = 1'b0;
        #1;
        chk("kill_idle_busy", int'(b32), 0);
        chk("kill_idle_count", int'(c32), 0);
        chk("kill_idle_op", int'(m32), 0);
        for (int k = 0; k < 30; k++) tick();

        // Kill in IDLE suppresses start
        v32 = 1'b1; k32 = 1'b1;
        #1;
        chk("kill_idle_start", int'(st32), 0);
        chk("kill_idle_stall", int'(sl32), 0);
        tick();
        v32 = 1'b0; k32 = 1'b0;
        #1;
        chk("kill_idle_nobusy", int'(b32), 0);

        // Asynchronous reset at Count=12, then a fresh MULTU
        tick();
        v32 = 1'b1;
        for (int k = 1; k <= 13; k++) tick();
        chk("rst_count12", int'(c32), 12);
        r32 = 1'b1;
        #1;
        chk("arst_busy", int'(b32), 0);
        chk("arst_stall", int'(sl32), 0);
        chk("arst_count", int'(c32), 0);
        chk("arst_op", int'(m32), 0);
        chk("arst_start", int'(st32), 0);
        chk("arst_hlw", int'(h32), 0);
        tick();
        r32 = 1'b0; v32 = 1'b0;
        tick();
        v32 = 1'b1;
        #1;
        t = cyc;
        chk("fresh_start", int'(st32), 1);
        q32.push_back('{t + 33, HILO});
        for (int k = 1; k <= 33; k++) tick();
        v32 = 1'b0;
        tick();

        // DIVU then MULTU back-to-back on the 8-bit instance
        v8 = 1'b1; a8 = 2'b10; f8 = DIVU;
        #1;
        t = cyc;
        chk("d8_start", int'(st8), 1);
        q8.push_back('{t + 9, HILO});
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) chk("d8_latched_op", int'(m8), int'(DIVU));
        end
        chk("d8_done_nostart", int'(st8), 0);
        tick();
        f8 = MULTU;
        #1;
        chk("m8_start_after_done", int'(st8), 1);
        q8.push_back('{t + 19, HILO});
        tick();
        f8 = 6'b100000;
        #1;
        chk("m8_latched_op", int'(m8), int'(MULTU));
        for (int k = 2; k <= 9; k++) tick();
        v8 = 1'b0;
        tick();

        // Kill during DONE suppresses the commit
        v8 = 1'b1; f8 = MULTU;
        for (int k = 1; k <= 9; k++) tick();
        chk("kd_busy", int'(b8), 1);
        k8 = 1'b1;
        #1;
        chk("kd_hlw", int'(h8), 0);
        tick();
        k8 = 1'b0; v8 = 1'b0;
        #1;
        chk("kd_idle", int'(b8), 0);

        // Instance without DIVU support
        tick();
        vn = 1'b1; an = 2'b10; fn = DIVU;
        #1;
        chk("nd_divu_start", int'(stn), 0);
        chk("nd_divu_stall", int'(sln), 0);
        tick();
        chk("nd_divu_busy", int'(bn), 0);
        vn = 1'b0; fn = MULTU;
        #1;
        chk("nv_multu_start", int'(stn), 0);
        tick();
        chk("nv_multu_busy", int'(bn), 0);
        vn = 1'b1;
        #1;
        t = cyc;
        chk("nd_multu_start", int'(stn), 1);
        qn.push_back('{t + 9, HILO});
        for (int k = 1; k <= 9; k++) tick();
        vn = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        chk("q32_drained", q32.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("qn_drained", qn.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
